// File: rtl/johnson_pkg.sv
// ============================================================================
//  Module      : johnson_pkg
//  Description : Shared types and helper functions for Johnson-code phase
//                decoding (state enum, successor, legality, phase index).
//                Functions take the code width as an argument and operate on
//                32-bit containers, so one package serves every WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package johnson_pkg;

    localparam int JOHNSON_MAX_W = 32;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } johnson_state_e;

    // All-ones mask covering the low w bits.
    function automatic logic [31:0] johnson_mask(input int w);
        return (w >= JOHNSON_MAX_W) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // MSB of a w-bit code, extracted with a shift to keep index widths exact.
    function automatic logic johnson_msb(input logic [31:0] c, input int w);
        return |(c & (32'd1 << (w - 1)));
    endfunction

    // Canonical successor: shift left, feed the inverted MSB into the LSB.
    function automatic logic [31:0] johnson_succ(input logic [31:0] c, input int w);
        logic [31:0] s;
        s = (c << 1) | {31'd0, ~johnson_msb(c, w)};
        return s & johnson_mask(w);
    endfunction

    // Legal when the ones (MSB=0) or the zeros (MSB=1) form a run from the LSB,
    // i.e. the relevant value has the form 2^k-1.
    function automatic logic johnson_legal(input logic [31:0] c, input int w);
        logic [31:0] x;
        logic [31:0] n;
        x = c & johnson_mask(w);
        n = johnson_msb(x, w) ? (~x & johnson_mask(w)) : x;
        return (n & (n + 32'd1)) == 32'd0;
    endfunction

    // Phase index of a legal code: popcount on the rising half, mirrored on
    // the falling half (all-ones lands on index w).
    function automatic logic [31:0] johnson_idx(input logic [31:0] c, input int w);
        int pc;
        pc = $countones(c & johnson_mask(w));
        return johnson_msb(c, w) ? 32'(2 * w - pc) : 32'(pc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_code_check.sv
// ============================================================================
//  Module      : johnson_code_check
//  Description : Combinational decode of one Johnson code word: legality flag,
//                binary phase index and one-hot phase (zero when illegal).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0]   code_i,
    output logic               legal_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [2*WIDTH-1:0] onehot_o
);

    localparam int PHASES = 2 * WIDTH;

    // Decode legality, index and one-hot for the presented code.
    always_comb begin
        legal_o  = johnson_legal(32'(code_i), WIDTH);
        idx_o    = IDX_W'(johnson_idx(32'(code_i), WIDTH));
        onehot_o = legal_o ? (PHASES'(1) << idx_o) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/johnson_phase_decoder.sv
// ============================================================================
//  Module      : johnson_phase_decoder
//  Description : Registers a one-hot phase and phase index from an upstream
//                Johnson counter, validates codes and steps, locks after
//                LOCK_STEPS good steps, counts laps while locked, flags errors.
//                Optional macro JOHNSON_DEC_ERRCNT_EN adds a saturating 8-bit
//                error counter port (err_count_o).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_STEPS = 2,
    parameter int LAP_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              code_i,
    input  logic                          code_valid_i,
    output logic [2*WIDTH-1:0]            phase_onehot_o,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx_o,
    output logic                          phase_valid_o,
    output logic                          locked_o,
    output logic [LAP_W-1:0]              lap_count_o,
    output logic                          err_o,
`ifdef JOHNSON_DEC_ERRCNT_EN
    output logic [7:0]                    err_count_o,
`endif
    output logic                          err_sticky_o
);

    localparam int                 PHASES   = 2 * WIDTH;
    localparam int                 IDX_W    = $clog2(PHASES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PHASES - 1);
    localparam logic [3:0]         LOCK_CNT = 4'(LOCK_STEPS);

    johnson_state_e       state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 prev_vld_q, prev_vld_d;
    logic [3:0]           step_cnt_q, step_cnt_d;
    logic [PHASES-1:0]    onehot_q, onehot_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic [LAP_W-1:0]     lap_q, lap_d;
    logic                 err_q, err_d;
    logic                 sticky_q, sticky_d;

    logic                 w_legal;
    logic [IDX_W-1:0]     w_idx;
    logic [PHASES-1:0]    w_onehot;
    logic [WIDTH-1:0]     w_succ;
    logic [IDX_W-1:0]     w_prev_idx;
    logic                 w_is_succ;
    logic                 w_is_same;

    johnson_code_check #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_check (
        .code_i   (code_i),
        .legal_o  (w_legal),
        .idx_o    (w_idx),
        .onehot_o (w_onehot)
    );

    // Relationship of the incoming code to the last accepted code.
    always_comb begin
        w_succ     = WIDTH'(johnson_succ(32'(prev_q), WIDTH));
        w_prev_idx = IDX_W'(johnson_idx(32'(prev_q), WIDTH));
        w_is_succ  = prev_vld_q && (code_i == w_succ);
        w_is_same  = prev_vld_q && (code_i == prev_q);
    end

    // Lock FSM next-state and output updates; idle cycles leave everything held.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        step_cnt_d = step_cnt_q;
        onehot_d   = onehot_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        lap_d      = lap_q;
        err_d      = 1'b0;
        sticky_d   = sticky_q;

        if (code_valid_i) begin
            case (state_q)
                UNLOCKED: begin
                    if (!w_legal) begin
                        err_d      = 1'b1;
                        sticky_d   = 1'b1;
                        step_cnt_d = '0;
                        valid_d    = 1'b0;
                        onehot_d   = '0;
                        prev_vld_d = 1'b0;
                    end else begin
                        prev_d     = code_i;
                        prev_vld_d = 1'b1;
                        valid_d    = 1'b1;
                        onehot_d   = w_onehot;
                        idx_d      = w_idx;
                        if (w_is_succ) begin
                            step_cnt_d = step_cnt_q + 4'd1;
                        end else if (!w_is_same) begin
                            step_cnt_d = '0;
                        end
                        if (step_cnt_d == LOCK_CNT) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (w_is_same) begin
                        // Upstream stall: nothing changes.
                    end else if (w_is_succ) begin
                        prev_d   = code_i;
                        onehot_d = w_onehot;
                        idx_d    = w_idx;
                        if ((w_prev_idx == LAST_IDX) && (w_idx == '0)) begin
                            lap_d = lap_q + 1'b1;
                        end
                    end else begin
                        err_d      = 1'b1;
                        sticky_d   = 1'b1;
                        state_d    = UNLOCKED;
                        step_cnt_d = '0;
                        if (w_legal) begin
                            prev_d     = code_i;
                            prev_vld_d = 1'b1;
                            valid_d    = 1'b1;
                            onehot_d   = w_onehot;
                            idx_d      = w_idx;
                        end else begin
                            prev_vld_d = 1'b0;
                            valid_d    = 1'b0;
                            onehot_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            step_cnt_q <= '0;
            onehot_q   <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            lap_q      <= '0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            step_cnt_q <= step_cnt_d;
            onehot_q   <= onehot_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            lap_q      <= lap_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of error pulses.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count_o = err_cnt_q;
`endif

    assign phase_onehot_o = onehot_q;
    assign phase_idx_o    = idx_q;
    assign phase_valid_o  = valid_q;
    assign locked_o       = (state_q == LOCKED);
    assign lap_count_o    = lap_q;
    assign err_o          = err_q;
    assign err_sticky_o   = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
// ============================================================================
//  Module      : tb_johnson_phase_decoder
//  Description : Scoreboard bench for johnson_phase_decoder (WIDTH=4).
//                A phase-level reference model predicts every cycle's outputs;
//                a monitor compares them one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_johnson_phase_decoder;

    localparam int W  = 4;
    localparam int LS = 2;
    localparam int LW = 8;
    localparam int P  = 2 * W;
    localparam int IW = $clog2(P);

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  code;
    logic          code_valid;
    logic [P-1:0]  phase_onehot;
    logic [IW-1:0] phase_idx;
    logic          phase_valid;
    logic          locked;
    logic [LW-1:0] lap_count;
    logic          err;
    logic          err_sticky;
    logic [7:0]    err_count;

    johnson_phase_decoder #(
        .WIDTH      (W),
        .LOCK_STEPS (LS),
        .LAP_W      (LW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .code_i         (code),
        .code_valid_i   (code_valid),
        .phase_onehot_o (phase_onehot),
        .phase_idx_o    (phase_idx),
        .phase_valid_o  (phase_valid),
        .locked_o       (locked),
        .lap_count_o    (lap_count),
        .err_o          (err),
`ifdef JOHNSON_DEC_ERRCNT_EN
        .err_count_o    (err_count),
`endif
        .err_sticky_o   (err_sticky)
    );

`ifndef JOHNSON_DEC_ERRCNT_EN
    assign err_count = 8'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0]  oh;
        logic [IW-1:0] idx;
        logic          valid;
        logic          locked;
        logic          err;
        logic          sticky;
        logic [LW-1:0] lap;
        logic [7:0]    ecnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase-number view of the code stream.
    logic [W-1:0] tbl [P];
    int           m_prev, m_steps, m_lap, m_ecnt, m_idx;
    bit           m_locked, m_err, m_sticky, m_valid;
    logic [P-1:0] m_oh;

    function automatic int lookup(input logic [W-1:0] c);
        for (int p = 0; p < P; p++) begin
            if (tbl[p] == c) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = -1; m_steps = 0; m_lap = 0; m_ecnt = 0; m_idx = 0;
        m_locked = 0; m_err = 0; m_sticky = 0; m_valid = 0; m_oh = '0;
    endtask

    task automatic model_error();
        m_err    = 1;
        m_sticky = 1;
        if (m_ecnt < 255) m_ecnt++;
    endtask

    task automatic model_show(input int ph);
        m_prev  = ph;
        m_valid = 1;
        m_idx   = ph;
        m_oh    = P'(1) << ph;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [W-1:0] c);
        int ph;
        m_err = 0;
        if (r) begin
            model_reset();
        end else if (v) begin
            ph = lookup(c);
            if (!m_locked) begin
                if (ph < 0) begin
                    model_error();
                    m_steps = 0; m_valid = 0; m_oh = '0; m_prev = -1;
                end else begin
                    if (m_prev >= 0 && ph == (m_prev + 1) % P) m_steps++;
                    else if (!(m_prev >= 0 && ph == m_prev)) m_steps = 0;
                    model_show(ph);
                    if (m_steps == LS) m_locked = 1;
                end
            end else if (ph == m_prev) begin
                // stall
            end else if (ph >= 0 && ph == (m_prev + 1) % P) begin
                if (m_prev == P - 1 && ph == 0) m_lap = (m_lap + 1) % (1 << LW);
                model_show(ph);
            end else begin
                model_error();
                m_locked = 0;
                m_steps  = 0;
                if (ph >= 0) model_show(ph);
                else begin
                    m_prev = -1; m_valid = 0; m_oh = '0;
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [W-1:0] c);
        exp_t e;
        @(negedge clk);
        reset      = r;
        code_valid = v;
        code       = c;
        model_step(r, v, c);
        e.oh     = m_oh;
        e.idx    = IW'(m_idx);
        e.valid  = m_valid;
        e.locked = m_locked;
        e.err    = m_err;
        e.sticky = m_sticky;
        e.lap    = LW'(m_lap);
        e.ecnt   = 8'(m_ecnt);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: each edge's registered outputs against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("phase_onehot", 32'(phase_onehot), 32'(e.oh));
                chk("phase_idx",    32'(phase_idx),    32'(e.idx));
                chk("phase_valid",  32'(phase_valid),  32'(e.valid));
                chk("locked",       32'(locked),       32'(e.locked));
                chk("err",          32'(err),          32'(e.err));
                chk("err_sticky",   32'(err_sticky),   32'(e.sticky));
                chk("lap_count",    32'(lap_count),    32'(e.lap));
`ifdef JOHNSON_DEC_ERRCNT_EN
                chk("err_count",    32'(err_count),    32'(e.ecnt));
`endif
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int ph;
        for (int p = 0; p < P; p++) begin
            if (p <= W) tbl[p] = W'((1 << p) - 1);
            else        tbl[p] = W'(((1 << W) - 1) ^ ((1 << (p - W)) - 1));
        end
        reset = 1'b1; code_valid = 1'b0; code = '0;
        model_reset();
        drive(1, 0, '0);
        drive(1, 0, '0);

        // Two full laps of the canonical sequence plus the wrap to 0000.
        for (int i = 0; i <= 2 * P; i++) drive(0, 1, tbl[i % P]);
        // Stall while locked, then advance.
        drive(0, 1, 4'b0001);
        drive(0, 1, 4'b0011);
        drive(0, 1, 4'b0011);
        drive(0, 1, 4'b0111);
        // Reverse step, relock, then a skip from 0011 to 1111.
        drive(0, 1, 4'b0011);
        drive(0, 1, 4'b0111);
        drive(0, 1, 4'b1111);
        drive(0, 1, 4'b1110);
        drive(0, 1, 4'b1100);
        drive(0, 1, 4'b1000);
        drive(0, 1, 4'b0000);
        drive(0, 1, 4'b0001);
        drive(0, 1, 4'b0011);
        drive(0, 1, 4'b1111);
        // Illegal code, then relock from scratch.
        drive(0, 1, 4'b0101);
        drive(0, 1, 4'b0000);
        drive(0, 1, 4'b0001);
        drive(0, 1, 4'b0011);
        // Idle with garbage on the bus.
        for (int i = 0; i < 10; i++) drive(0, 0, W'($urandom));
        drive(0, 1, 4'b0111);
        // Reset while locked and valid.
        drive(1, 1, 4'b1111);
        // Long illegal burst (drives err_count into saturation when present).
        for (int i = 0; i < 300; i++) drive(0, 1, 4'b0101);
        drive(0, 1, 4'b1010);

        // Randomized walk.
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            ph = (m_prev >= 0) ? m_prev : $urandom_range(0, P - 1);
            if (r < 2)       drive(1, $urandom_range(0, 1), W'($urandom));
            else if (r < 12) drive(0, 0, W'($urandom));
            else if (r < 72) drive(0, 1, tbl[(ph + 1) % P]);
            else if (r < 80) drive(0, 1, tbl[ph]);
            else if (r < 90) drive(0, 1, tbl[$urandom_range(0, P - 1)]);
            else             drive(0, 1, W'($urandom));
        end

        drive(0, 0, '0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
